// File: rtl/pr_cfg_rd_engine_if.sv
// Bus bundle for the partial-reconfiguration read engine: transfer control,
// DMA read-request handshake, completion beats, buffer drain and status.
interface pr_cfg_rd_engine_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned LEN_W  = 32
);
  logic              start;
  logic [ADDR_W-1:0] src_addr;
  logic [LEN_W-1:0]  len;
  logic              abort;

  logic              rd_req;
  logic [ADDR_W-1:0] rd_req_addr;
  logic [11:0]       rd_req_len;
  logic [7:0]        rd_req_tag;
  logic              rd_req_ack;

  logic              cpl_valid;
  logic [7:0]        cpl_tag;
  logic              buf_rd;

  logic              busy;
  logic              done;
  logic              done_ack;
  logic              err;
  logic              aborted;
  logic [LEN_W-1:0]  bytes_rcvd;

  // Engine side
  modport master (
    input  start, src_addr, len, abort, rd_req_ack, cpl_valid, cpl_tag, buf_rd, done_ack,
    output rd_req, rd_req_addr, rd_req_len, rd_req_tag, busy, done, err, aborted, bytes_rcvd
  );

  // Host / arbiter / buffer side
  modport slave (
    output start, src_addr, len, abort, rd_req_ack, cpl_valid, cpl_tag, buf_rd, done_ack,
    input  rd_req, rd_req_addr, rd_req_len, rd_req_tag, busy, done, err, aborted, bytes_rcvd
  );
endinterface

// File: rtl/pr_cfg_rd_engine.sv
// Bitstream read engine: splits a host region into boundary-respecting DMA
// read requests, tracks tagged requests in flight and gates issue on
// downstream buffer credits.
module pr_cfg_rd_engine #(
  parameter int unsigned ADDR_W          = 32,
  parameter int unsigned LEN_W           = 32,
  parameter int unsigned MAX_REQ_BYTES   = 4096,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned BUF_BYTES       = 16384,
  parameter int unsigned DATA_BYTES      = 16
) (
  input logic                i_pcie_clk,
  input logic                i_rst,
  pr_cfg_rd_engine_if.master bus
);
  localparam int unsigned OffW     = $clog2(MAX_REQ_BYTES);
  localparam int unsigned BeatOffW = $clog2(DATA_BYTES);
  localparam int unsigned UsedW    = $clog2(BUF_BYTES + 1);
  localparam int unsigned BeatW    = $clog2(MAX_REQ_BYTES / DATA_BYTES + 1);
  localparam int unsigned TagW     = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  typedef enum logic [2:0] {StIdle, StIssue, StWaitAck, StDrain, StDone} state_e;

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  addr_q;
  logic [LEN_W-1:0]   rem_q;
  logic [UsedW-1:0]   used_q, used_d, used_sum;
  logic [BeatW-1:0]   beats_q [MAX_OUTSTANDING];
  logic [BeatW-1:0]   beats_d [MAX_OUTSTANDING];
  logic [UsedW-1:0]   req_chunk_q;
  logic [TagW-1:0]    req_tag_q;
  logic               abort_seen_q, err_q, aborted_q;
  logic [LEN_W-1:0]   bytes_q;

  logic [ADDR_W-1:0]  start_addr;
  logic [LEN_W-1:0]   start_len;
  logic [UsedW-1:0]   room, chunk;
  logic               credit_ok, free_found, all_free, abort_now;
  logic [TagW-1:0]    free_tag;
  logic               issue_go, ack_fire, cpl_hit, cpl_miss;

  assign start_addr = bus.src_addr & ~ADDR_W'(DATA_BYTES - 1);
  assign start_len  = bus.len & ~LEN_W'(DATA_BYTES - 1);
  // An abort pulse seen while a request was pending still ends issuing later
  assign abort_now  = bus.abort || abort_seen_q;
  assign ack_fire   = (state_q == StWaitAck) && bus.rd_req_ack;

  // Next request size, credit check and lowest free tag
  always_comb begin
    room       = UsedW'(MAX_REQ_BYTES) - UsedW'(addr_q[OffW-1:0]);
    chunk      = (rem_q < LEN_W'(room)) ? UsedW'(rem_q) : room;
    credit_ok  = (UsedW'(BUF_BYTES) - used_q) >= chunk;
    free_found = 1'b0;
    all_free   = 1'b1;
    free_tag   = '0;
    for (int t = int'(MAX_OUTSTANDING) - 1; t >= 0; t--) begin
      if (beats_q[t] == '0) begin
        free_found = 1'b1;
        free_tag   = TagW'(t);
      end else begin
        all_free = 1'b0;
      end
    end
    issue_go = (state_q == StIssue) && !abort_now && (rem_q != '0) && free_found && credit_ok;
  end

  // Per-tag beat tracking: completions count down, an ack loads the new count
  always_comb begin
    beats_d  = beats_q;
    cpl_hit  = 1'b0;
    cpl_miss = 1'b0;
    if (state_q != StIdle && bus.cpl_valid) begin
      cpl_miss = 1'b1;
      for (int t = 0; t < int'(MAX_OUTSTANDING); t++) begin
        if (bus.cpl_tag == 8'(t) && beats_q[t] != '0) begin
          beats_d[t] = beats_q[t] - 1'b1;
          cpl_hit    = 1'b1;
          cpl_miss   = 1'b0;
        end
      end
    end
    for (int t = 0; t < int'(MAX_OUTSTANDING); t++) begin
      if (ack_fire && req_tag_q == TagW'(t)) begin
        beats_d[t] = BeatW'(req_chunk_q >> BeatOffW);
      end
    end
  end

  // Credit usage: ack adds the request size, each drained beat returns credit
  always_comb begin
    used_sum = used_q + (ack_fire ? req_chunk_q : '0);
    used_d   = used_sum;
    if (bus.buf_rd) begin
      used_d = (used_sum >= UsedW'(DATA_BYTES)) ? used_sum - UsedW'(DATA_BYTES) : '0;
    end
  end

  // FSM state register
  always_ff @(posedge i_pcie_clk) begin
    if (i_rst) state_q <= StIdle;
    else       state_q <= state_d;
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start) state_d = (start_len == '0) ? StDone : StIssue;
      end
      StIssue: begin
        if (abort_now || rem_q == '0)   state_d = StDrain;
        else if (free_found && credit_ok) state_d = StWaitAck;
      end
      StWaitAck: begin
        if (bus.rd_req_ack) state_d = StIssue;
      end
      StDrain: begin
        if (all_free) state_d = StDone;
      end
      StDone: begin
        if (bus.done_ack) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Datapath: address/remaining walk, request latch, tags, credits, status
  always_ff @(posedge i_pcie_clk) begin
    if (i_rst) begin
      addr_q       <= '0;
      rem_q        <= '0;
      used_q       <= '0;
      req_chunk_q  <= '0;
      req_tag_q    <= '0;
      abort_seen_q <= 1'b0;
      err_q        <= 1'b0;
      aborted_q    <= 1'b0;
      bytes_q      <= '0;
      for (int t = 0; t < int'(MAX_OUTSTANDING); t++) beats_q[t] <= '0;
    end else begin
      used_q  <= used_d;
      beats_q <= beats_d;
      if (state_q == StIdle) begin
        if (bus.start) begin
          addr_q       <= start_addr;
          rem_q        <= start_len;
          err_q        <= 1'b0;
          aborted_q    <= 1'b0;
          bytes_q      <= '0;
          abort_seen_q <= 1'b0;
        end
      end else begin
        if (bus.abort && state_q != StDone) abort_seen_q <= 1'b1;
        if (issue_go) begin
          req_chunk_q <= chunk;
          req_tag_q   <= free_tag;
        end
        if (ack_fire) begin
          addr_q <= addr_q + ADDR_W'(req_chunk_q);
          rem_q  <= rem_q - LEN_W'(req_chunk_q);
        end
        if (cpl_hit)  bytes_q <= bytes_q + LEN_W'(DATA_BYTES);
        if (cpl_miss) err_q   <= 1'b1;
        if (state_q == StDrain && all_free && abort_now) aborted_q <= 1'b1;
      end
    end
  end

  // FSM outputs; request fields read as zero while no request is pending
  always_comb begin
    bus.rd_req      = (state_q == StWaitAck);
    bus.rd_req_addr = (state_q == StWaitAck) ? addr_q : '0;
    bus.rd_req_len  = (state_q == StWaitAck) ? 12'(req_chunk_q) : '0;
    bus.rd_req_tag  = (state_q == StWaitAck) ? 8'(req_tag_q) : '0;
    bus.busy        = (state_q != StIdle);
    bus.done        = (state_q == StDone);
    bus.err         = err_q;
    bus.aborted     = aborted_q;
    bus.bytes_rcvd  = bytes_q;
  end
endmodule

// File: tb/tb_pr_cfg_rd_engine.sv
// Bench for pr_cfg_rd_engine: table-driven transfers with a request
// scoreboard, plus hand-written credit, tag, abort, error and reset sequences.
module tb_pr_cfg_rd_engine;
  localparam int unsigned MaxOut   = 2;
  localparam int unsigned BufBytes = 8192;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pr_cfg_rd_engine_if #(.ADDR_W(32), .LEN_W(32)) rif ();

  pr_cfg_rd_engine #(
    .ADDR_W(32), .LEN_W(32), .MAX_REQ_BYTES(4096), .MAX_OUTSTANDING(MaxOut),
    .BUF_BYTES(BufBytes), .DATA_BYTES(16)
  ) dut (
    .i_pcie_clk(clk),
    .i_rst(rst),
    .bus(rif)
  );

  typedef struct {
    logic [31:0] addr;
    logic [11:0] len;
    logic [7:0]  tag;
  } req_t;

  typedef struct {
    logic [31:0] src_addr;
    logic [31:0] len;
    int          nreq;
    logic [31:0] a0;
    logic [11:0] l0;
    logic [31:0] a1;
    logic [11:0] l1;
    logic [31:0] bytes;
  } vec_t;

  req_t exp_q[$];
  vec_t vecs[7];
  int   n_chk = 0;
  int   n_pass = 0;
  int   nreq;
  int   pend[8];
  bit   auto_ack, auto_cpl, ack_pend;
  int   ack_tag, ack_beats;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic push_req(input logic [31:0] a, input logic [11:0] l, input logic [7:0] t);
    req_t r;
    r.addr = a; r.len = l; r.tag = t;
    exp_q.push_back(r);
  endtask

  task automatic check_req();
    req_t e;
    if (exp_q.size() == 0) begin
      n_chk++;
      $display("FAIL unexpected_req: got addr 0x%0h tag %0d, expected no request",
               rif.rd_req_addr, rif.rd_req_tag);
    end else begin
      e = exp_q.pop_front();
      chk("req_addr", rif.rd_req_addr, e.addr);
      chk("req_len", rif.rd_req_len, e.len);
      chk("req_tag", rif.rd_req_tag, e.tag);
    end
  endtask

  // One cycle: respond to requests (ack) and return completion beats
  task automatic step();
    @(negedge clk);
    if (ack_pend) begin
      rif.rd_req_ack = 1'b0;
      ack_pend = 1'b0;
      if (ack_tag < 8) pend[ack_tag] += ack_beats;
    end else if (auto_ack && rif.rd_req === 1'b1) begin
      check_req();
      ack_pend = 1'b1;
      rif.rd_req_ack = 1'b1;
      ack_tag = int'(rif.rd_req_tag);
      ack_beats = (rif.rd_req_len == 12'h000) ? 256 : int'(rif.rd_req_len) / 16;
      nreq++;
    end
    if (auto_cpl) begin
      rif.cpl_valid = 1'b0;
      for (int t = 0; t < 8; t++) begin
        if (pend[t] > 0) begin
          rif.cpl_valid = 1'b1;
          rif.cpl_tag = 8'(t);
          pend[t]--;
          break;
        end
      end
    end
  endtask

  task automatic start_xfer(input logic [31:0] a, input logic [31:0] l);
    rif.start = 1'b1; rif.src_addr = a; rif.len = l;
    nreq = 0;
    step();
    rif.start = 1'b0;
    chk("start_err_clr", rif.err, 0);
    chk("start_abort_clr", rif.aborted, 0);
    chk("start_bytes_clr", rif.bytes_rcvd, 0);
    chk("start_busy", rif.busy, 1);
  endtask

  task automatic wait_done(input int budget);
    int i = 0;
    while (rif.done !== 1'b1 && i < budget) begin
      step();
      i++;
    end
    chk("done_seen", rif.done, 1);
  endtask

  // Acknowledge done, then return every possible credit to start clean
  task automatic finish_xfer();
    rif.done_ack = 1'b1;
    step();
    rif.done_ack = 1'b0;
    chk("idle_busy", rif.busy, 0);
    chk("idle_done", rif.done, 0);
    auto_ack = 1'b0;
    auto_cpl = 1'b0;
    rif.cpl_valid = 1'b0;
    rif.buf_rd = 1'b1;
    repeat (BufBytes / 16 + 2) step();
    rif.buf_rd = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    if (v.nreq > 0) push_req(v.a0, v.l0, 8'd0);
    if (v.nreq > 1) push_req(v.a1, v.l1, 8'd1);
    start_xfer(v.src_addr, v.len);
    auto_ack = 1'b1;
    auto_cpl = 1'b0;
    for (int i = 0; i < 60 && nreq < v.nreq; i++) step();
    auto_cpl = 1'b1;
    wait_done(3000);
    chk("vec_nreq", nreq, v.nreq);
    chk("vec_sb_empty", exp_q.size(), 0);
    chk("vec_bytes", rif.bytes_rcvd, v.bytes);
    chk("vec_aborted", rif.aborted, 0);
    chk("vec_err", rif.err, 0);
    finish_xfer();
  endtask

  initial begin
    #3_000_000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    int   early;
    vec_t clean;
    vecs[0] = '{32'h10000F00, 32'h400,  2, 32'h10000F00, 12'h100, 32'h10001000, 12'h300, 32'h400};
    vecs[1] = '{32'h00000000, 32'h2000, 2, 32'h00000000, 12'h000, 32'h00001000, 12'h000, 32'h2000};
    vecs[2] = '{32'h20000010, 32'h20,   1, 32'h20000010, 12'h020, 32'h0,        12'h000, 32'h20};
    vecs[3] = '{32'h30000FF7, 32'h1F,   1, 32'h30000FF0, 12'h010, 32'h0,        12'h000, 32'h10};
    vecs[4] = '{32'h40000000, 32'h0,    0, 32'h0,        12'h000, 32'h0,        12'h000, 32'h0};
    vecs[5] = '{32'hFFFFFF00, 32'h200,  2, 32'hFFFFFF00, 12'h100, 32'h00000000, 12'h100, 32'h200};
    vecs[6] = '{32'h12345670, 32'h1000, 2, 32'h12345670, 12'h990, 32'h12346000, 12'h670, 32'h1000};
    clean   = '{32'h00005000, 32'h40,   1, 32'h00005000, 12'h040, 32'h0,        12'h000, 32'h40};

    rif.start = 0; rif.src_addr = 0; rif.len = 0; rif.abort = 0; rif.rd_req_ack = 0;
    rif.cpl_valid = 0; rif.cpl_tag = 0; rif.buf_rd = 0; rif.done_ack = 0;
    auto_ack = 0; auto_cpl = 0; ack_pend = 0; nreq = 0;
    foreach (pend[t]) pend[t] = 0;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_rd_req", rif.rd_req, 0);
    chk("rst_req_addr", rif.rd_req_addr, 0);
    chk("rst_busy", rif.busy, 0);
    chk("rst_done", rif.done, 0);
    chk("rst_err", rif.err, 0);
    chk("rst_aborted", rif.aborted, 0);
    chk("rst_bytes", rif.bytes_rcvd, 0);
    rst = 1'b0;
    step();

    for (int v = 0; v < 7; v++) run_vec(vecs[v]);

    // Credit stall: two full requests exhaust the 8 KiB buffer
    push_req(32'h0, 12'h000, 8'd0);
    push_req(32'h1000, 12'h000, 8'd1);
    push_req(32'h2000, 12'h000, 8'd0);
    start_xfer(32'h0, 32'h4000);
    auto_ack = 1'b1; auto_cpl = 1'b1;
    repeat (700) step();
    chk("credit_stall_nreq", nreq, 2);
    auto_ack = 1'b0;
    early = 0;
    for (int i = 0; i < 256; i++) begin
      rif.buf_rd = 1'b1;
      step();
      if (rif.rd_req === 1'b1) early++;
    end
    rif.buf_rd = 1'b0;
    chk("credit_no_early_req", early, 0);
    auto_ack = 1'b1;
    for (int i = 0; i < 2 && nreq < 3; i++) step();
    chk("credit_resume_nreq", nreq, 3);
    rif.abort = 1'b1; step(); rif.abort = 1'b0;
    wait_done(1000);
    chk("credit_nreq_final", nreq, 3);
    chk("credit_aborted", rif.aborted, 1);
    chk("credit_bytes", rif.bytes_rcvd, 32'h3000);
    chk("credit_sb_empty", exp_q.size(), 0);
    finish_xfer();

    // Tag limit: two tags in flight, credits available, no completions
    push_req(32'h0, 12'h000, 8'd0);
    push_req(32'h1000, 12'h000, 8'd1);
    start_xfer(32'h0, 32'h4000);
    auto_ack = 1'b1; auto_cpl = 1'b0;
    repeat (20) step();
    chk("tag_limit_nreq", nreq, 2);
    rif.buf_rd = 1'b1;
    repeat (256) step();
    rif.buf_rd = 1'b0;
    repeat (5) step();
    chk("tag_limit_hold", nreq, 2);
    push_req(32'h2000, 12'h000, 8'd0);
    auto_cpl = 1'b1;
    for (int i = 0; i < 600 && nreq < 3; i++) step();
    chk("tag_reuse_nreq", nreq, 3);
    rif.abort = 1'b1; step(); rif.abort = 1'b0;
    wait_done(1500);
    chk("tag_aborted", rif.aborted, 1);
    chk("tag_bytes", rif.bytes_rcvd, 32'h3000);
    chk("tag_sb_empty", exp_q.size(), 0);
    finish_xfer();

    // Abort while a request waits for its ack
    push_req(32'h8000, 12'h000, 8'd0);
    start_xfer(32'h8000, 32'h2000);
    auto_ack = 1'b0; auto_cpl = 1'b0;
    for (int i = 0; i < 10 && rif.rd_req !== 1'b1; i++) step();
    chk("abort_req_seen", rif.rd_req, 1);
    rif.abort = 1'b1; step(); rif.abort = 1'b0;
    repeat (3) step();
    chk("abort_req_held", rif.rd_req, 1);
    chk("abort_addr_held", rif.rd_req_addr, 32'h8000);
    auto_ack = 1'b1; auto_cpl = 1'b1;
    wait_done(600);
    chk("abort_nreq", nreq, 1);
    chk("abort_aborted", rif.aborted, 1);
    chk("abort_bytes", rif.bytes_rcvd, 32'h1000);
    chk("abort_sb_empty", exp_q.size(), 0);
    finish_xfer();

    // Completion beat on an unallocated tag
    push_req(32'h40, 12'h020, 8'd0);
    start_xfer(32'h40, 32'h20);
    auto_ack = 1'b1; auto_cpl = 1'b0;
    for (int i = 0; i < 10 && nreq < 1; i++) step();
    step();
    rif.cpl_valid = 1'b1; rif.cpl_tag = 8'd5;
    step();
    rif.cpl_valid = 1'b0;
    chk("err_set", rif.err, 1);
    chk("err_bytes_unchanged", rif.bytes_rcvd, 0);
    auto_cpl = 1'b1;
    wait_done(100);
    chk("err_bytes_final", rif.bytes_rcvd, 32'h20);
    chk("err_sticky", rif.err, 1);
    finish_xfer();
    run_vec(vecs[2]);

    // Reset during WAIT_ACK, then a clean transfer
    push_req(32'h100, 12'h100, 8'd0);
    start_xfer(32'h100, 32'h100);
    auto_ack = 1'b0;
    for (int i = 0; i < 10 && rif.rd_req !== 1'b1; i++) step();
    chk("rst_mid_req_seen", rif.rd_req, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_mid_rd_req", rif.rd_req, 0);
    chk("rst_mid_busy", rif.busy, 0);
    chk("rst_mid_done", rif.done, 0);
    exp_q.delete();
    foreach (pend[t]) pend[t] = 0;
    ack_pend = 1'b0;
    rif.rd_req_ack = 1'b0;
    step();
    run_vec(clean);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
